// File: rtl/nco_pkg.sv
// ---------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the burst NCO: FSM state encoding, pipeline latency,
// quadrant-decode bit positions and the quarter-wave sine table generator.
// ---------------------------------------------------------------------------
package nco_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Accumulator-to-output latency; DRAIN lasts this many clocks.
    localparam int PIPE_LAT = 3;

    // Quadrant q = phase[MSB:MSB-1]: q[0] mirrors the LUT index, q[1] negates.
    localparam int Q_MIRROR_BIT = 0;
    localparam int Q_SIGN_BIT   = 1;

    localparam real HALF_PI = 1.5707963267948966;

    // Entry k of the quarter-wave table, sampled at bin centres (k + 0.5) so
    // that mirroring about the quarter point is exact and the table never
    // contains sin(0) or sin(pi/2).
    function automatic int lut_entry(input int k, input int lut_aw, input int out_w);
        real amp;
        real ang;
        amp = $itor((1 << (out_w - 1)) - 1);
        ang = HALF_PI * ($itor(k) + 0.5) / $itor(1 << lut_aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sin_quarter_lut.sv
// ---------------------------------------------------------------------------
// sin_quarter_lut
// Registered quarter-wave sine ROM holding non-negative magnitudes.
// Optional build macro: COS_OUT_EN adds a second read port (addr_b/data_b).
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (clears read registers)
//   addr_a  in   LUT_AW-bit read address, port A
//   data_a  out  OUT_W-bit magnitude, one clock after addr_a
//   addr_b  in   (COS_OUT_EN) read address, port B
//   data_b  out  (COS_OUT_EN) magnitude, one clock after addr_b
// ---------------------------------------------------------------------------
module sin_quarter_lut
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] addr_a,
`ifdef COS_OUT_EN
    input  logic [LUT_AW-1:0] addr_b,
    output logic [OUT_W-1:0]  data_b,
`endif
    output logic [OUT_W-1:0]  data_a
);

    localparam int LUT_N = 1 << LUT_AW;

    logic [OUT_W-1:0] rom [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        assign rom[k] = OUT_W'(lut_entry(k, LUT_AW, OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a <= '0;
        end else begin
            data_a <= rom[addr_a];
        end
    end

`ifdef COS_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_b <= '0;
        end else begin
            data_b <= rom[addr_b];
        end
    end
`endif

endmodule

// File: rtl/nco_burst_sin.sv
// ---------------------------------------------------------------------------
// nco_burst_sin
// Multi-channel phase-accumulator NCO with quarter-wave sine LUT and burst
// sequencing. All channels share one accumulator; each adds its own live
// phase offset. Bursts are counted in whole carrier periods (accumulator
// carry-outs); burst_len = 0 runs until stop.
// Optional build macro: COS_OUT_EN adds cos_out (quadrature, +90 degrees),
// using a second read port on each channel's LUT.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin burst (IDLE only; stop in the same clock wins)
//   stop       in   abort burst (RUN only), enters DRAIN
//   freq_word  in   phase increment per clock, latched at start
//   burst_len  in   carrier periods per burst, latched at start
//   ch_offset  in   N_CH packed phase offsets, channel i at [i*PHASE_W +: PHASE_W]
//   sin_out    out  N_CH packed signed samples, same packing
//   cos_out    out  (COS_OUT_EN) quadrature samples, same packing
//   out_valid  out  sin_out holds a sample from the current burst
//   busy       out  state is not IDLE
//   done       out  one-clock pulse on the last DRAIN clock
// ---------------------------------------------------------------------------
module nco_burst_sin
    import nco_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 16,
    parameter int LUT_AW  = 8,
    parameter int N_CH    = 4,
    parameter int BURST_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PHASE_W-1:0]      freq_word,
    input  logic [BURST_W-1:0]      burst_len,
    input  logic [N_CH*PHASE_W-1:0] ch_offset,
    output logic [N_CH*OUT_W-1:0]   sin_out,
`ifdef COS_OUT_EN
    output logic [N_CH*OUT_W-1:0]   cos_out,
`endif
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done
);

    localparam logic [BURST_W-1:0] ONE_B      = BURST_W'(1);
    localparam logic [1:0]         DRAIN_LAST = 2'(PIPE_LAT - 1);

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic neg,
                                                            input logic [OUT_W-1:0] mag);
        // Table magnitudes never exceed 2^(OUT_W-1)-1, so negation cannot overflow.
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    state_t               state_q, state_d;
    logic                 load;
    logic [1:0]           drain_cnt_q;
    logic [PHASE_W-1:0]   acc_q, acc_sum, freq_q;
    logic                 carry;
    logic [BURST_W-1:0]   periods_q, burst_len_q;
    logic                 last_period;
    logic                 vld_p1, vld_p2, vld_p3;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, freq_q};
    assign last_period = (burst_len_q != '0) && carry && (periods_q == burst_len_q - ONE_B);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (stop || last_period) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = vld_p3;

    // Stage 0: FSM, accumulator and period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            acc_q       <= '0;
            freq_q      <= '0;
            periods_q   <= '0;
            burst_len_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q + 2'd1;
            end else begin
                drain_cnt_q <= '0;
            end
            if (load) begin
                acc_q       <= '0;
                periods_q   <= '0;
                freq_q      <= freq_word;
                burst_len_q <= burst_len;
            end else if (state_q == RUN) begin
                acc_q <= acc_sum;
                if (carry) begin
                    periods_q <= periods_q + ONE_B;
                end
            end
        end
    end

    // Valid tag travelling with stages 1..3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p1 <= (state_q == RUN);
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PHASE_W-1:0]      ph;
        logic [1:0]              q;
        logic [LUT_AW-1:0]       idx;
        logic                    unused_ph;
        logic [LUT_AW-1:0]       addr_p1;
        logic                    sign_p1, sign_p2;
        logic [OUT_W-1:0]        mag_p2;
        logic signed [OUT_W-1:0] sin_p3;

        // Phase bits below the LUT index are dropped (no interpolation).
        assign ph        = acc_q + ch_offset[i*PHASE_W +: PHASE_W];
        assign q         = ph[PHASE_W-1 -: 2];
        assign idx       = ph[PHASE_W-3 -: LUT_AW];
        assign unused_ph = ^ph;

`ifdef COS_OUT_EN
        // +90 degrees only moves the quadrant; the index bits are unchanged.
        logic [1:0]              qc;
        logic [LUT_AW-1:0]       addr_c_p1;
        logic                    sign_c_p1, sign_c_p2;
        logic [OUT_W-1:0]        mag_c_p2;
        logic signed [OUT_W-1:0] cos_p3;

        assign qc = q + 2'd1;
`endif

        // Stage 1: offset add, quadrant decode, index mirror
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_p1 <= '0;
                sign_p1 <= 1'b0;
`ifdef COS_OUT_EN
                addr_c_p1 <= '0;
                sign_c_p1 <= 1'b0;
`endif
            end else begin
                addr_p1 <= q[Q_MIRROR_BIT] ? ~idx : idx;
                sign_p1 <= q[Q_SIGN_BIT];
`ifdef COS_OUT_EN
                addr_c_p1 <= qc[Q_MIRROR_BIT] ? ~idx : idx;
                sign_c_p1 <= qc[Q_SIGN_BIT];
`endif
            end
        end

        // Stage 2: registered LUT read
        sin_quarter_lut #(
            .LUT_AW (LUT_AW),
            .OUT_W  (OUT_W)
        ) u_lut (
            .clk    (clk),
            .rst_n  (rst_n),
            .addr_a (addr_p1),
`ifdef COS_OUT_EN
            .addr_b (addr_c_p1),
            .data_b (mag_c_p2),
`endif
            .data_a (mag_p2)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sign_p2 <= 1'b0;
`ifdef COS_OUT_EN
                sign_c_p2 <= 1'b0;
`endif
            end else begin
                sign_p2 <= sign_p1;
`ifdef COS_OUT_EN
                sign_c_p2 <= sign_c_p1;
`endif
            end
        end

        // Stage 3: sign restore; output held at zero outside a burst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sin_p3 <= '0;
`ifdef COS_OUT_EN
                cos_p3 <= '0;
`endif
            end else begin
                sin_p3 <= vld_p2 ? apply_sign(sign_p2, mag_p2) : '0;
`ifdef COS_OUT_EN
                cos_p3 <= vld_p2 ? apply_sign(sign_c_p2, mag_c_p2) : '0;
`endif
            end
        end

        assign sin_out[i*OUT_W +: OUT_W] = sin_p3;
`ifdef COS_OUT_EN
        assign cos_out[i*OUT_W +: OUT_W] = cos_p3;
`endif
    end

endmodule

// File: tb/tb_nco_burst_sin.sv
// ---------------------------------------------------------------------------
// tb_nco_burst_sin
// Directed bench for nco_burst_sin with default parameters. Stimulus pushes
// the expected samples into a scoreboard queue; a monitor pops one entry per
// valid output cycle and compares every channel.
// ---------------------------------------------------------------------------
module tb_nco_burst_sin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] freq_word;
    logic [15:0] burst_len;
    logic [63:0] ch_offset;
    logic [63:0] sin_out;
`ifdef COS_OUT_EN
    logic [63:0] cos_out;
`endif
    logic        out_valid;
    logic        busy;
    logic        done;

    nco_burst_sin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .freq_word (freq_word),
        .burst_len (burst_len),
        .ch_offset (ch_offset),
        .sin_out   (sin_out),
`ifdef COS_OUT_EN
        .cos_out   (cos_out),
`endif
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             chk;
        logic             chkc;
        logic [3:0][15:0] s;
        logic [3:0][15:0] c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d", name, act, req);
    endtask

    // Samples at phases 0, 1/4, 1/2, 3/4 of a turn with LUT_AW=8, OUT_W=16.
    function automatic int w_of(input int k);
        int t [4];
        t = '{101, 32767, -101, -32767};
        return t[k % 4];
    endfunction

    // Push n samples for a quarter-turn step; channel c is offset by qoff[c] quarters.
    task automatic push_quarters(input int n, input logic [3:0][1:0] qoff);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.chk  = 1'b1;
            e.chkc = 1'b1;
            for (int c = 0; c < 4; c++) begin
                e.s[c] = 16'(w_of(k + int'(qoff[c])));
                e.c[c] = 16'(w_of(k + int'(qoff[c]) + 1));
            end
            sb.push_back(e);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int waited);
        waited = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (done) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_one_clk"}, done, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    // Monitor: pop and compare on every valid output cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                check("sb_has_entry_on_valid", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    for (int c = 0; c < 4; c++) begin
                        if (mon_e.chk)
                            check($sformatf("sin_ch%0d", c),
                                  longint'($signed(sin_out[c*16 +: 16])),
                                  longint'($signed(mon_e.s[c])));
`ifdef COS_OUT_EN
                        if (mon_e.chkc)
                            check($sformatf("cos_ch%0d", c),
                                  longint'($signed(cos_out[c*16 +: 16])),
                                  longint'($signed(mon_e.c[c])));
`endif
                    end
                end
            end else begin
                check("sin_zero_when_invalid", sin_out, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1);
    end

    initial begin
        int   w;
        int   seen;
        exp_t e;

        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        freq_word = '0;
        burst_len = '0;
        ch_offset = '0;
        repeat (3) @(negedge clk);
        check("rst_sin_out", sin_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: quarter-turn step, two periods, zero offsets
        freq_word = 16'h4000;
        burst_len = 16'd2;
        push_quarters(8, '0);
        start_pulse();
        check("t1_busy", busy, 1);
        wait_done(20, w);
        check("t1_done_latency", w, 10);
        after_done("t1");

        // Test 2: per-channel quarter offsets
        ch_offset = {16'hC000, 16'h8000, 16'h4000, 16'h0000};
        push_quarters(8, {2'd3, 2'd2, 2'd1, 2'd0});
        start_pulse();
        wait_done(20, w);
        check("t2_done_latency", w, 10);
        after_done("t2");

        // Test 3: continuous mode, stop after 500 RUN clocks
        ch_offset = '0;
        freq_word = 16'h00C0;
        burst_len = 16'd0;
        for (int k = 0; k < 500; k++) begin
            e.chk  = (k < 2);
            e.chkc = 1'b0;
            for (int c = 0; c < 4; c++) begin
                e.s[c] = (k == 0) ? 16'd101 : 16'd704;
                e.c[c] = '0;
            end
            sb.push_back(e);
        end
        start_pulse();
        repeat (499) @(negedge clk);
        check("t3_still_busy", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(10, w);
        check("t3_done_seen", (w > 0), 1);
        after_done("t3");

        // Test 4: start and stop together in IDLE
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (busy || out_valid || done) seen++;
        end
        check("t4_no_burst", seen, 0);

        // Test 5: asynchronous reset mid-burst, then a fresh burst
        freq_word = 16'h4000;
        burst_len = 16'd0;
        push_quarters(2, '0);
        start_pulse();
        repeat (4) @(negedge clk);
        check("t5_valid_before_rst", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_sin_out", sin_out, 0);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_samples_before_rst", sb.size(), 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        burst_len = 16'd1;
        push_quarters(4, '0);
        start_pulse();
        wait_done(20, w);
        check("t5_done_latency", w, 6);
        after_done("t5");

        // Test 6: freq_word change during a burst is ignored
        freq_word = 16'h4000;
        burst_len = 16'd2;
        push_quarters(8, '0);
        start_pulse();
        freq_word = 16'h1000;
        burst_len = 16'd7;
        wait_done(20, w);
        check("t6_done_latency", w, 10);
        after_done("t6");

        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
